// File: rtl/rs_issue_queue_pkg.sv
// Shared types for the reservation station: dispatched micro-op and stored entry formats.
package rs_issue_queue_pkg;

    localparam int PREG_W = 8;
    localparam int ROB_W  = 4;
    localparam int OPC_W  = 7;
    localparam int IMM_W  = 16;
    // Wide enough for the largest supported issue width (4 ports).
    localparam int FU_W   = 2;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] pr1;
        logic [PREG_W-1:0] pr2;
        logic [IMM_W-1:0]  imm;
        logic [ROB_W-1:0]  rob_index;
    } dispatch_pipeline_data;

    typedef struct packed {
        logic              valid;
        logic [OPC_W-1:0]  opcode;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] pr1;
        logic              pr1_ready;
        logic [PREG_W-1:0] pr2;
        logic              pr2_ready;
        logic [IMM_W-1:0]  imm;
        logic [ROB_W-1:0]  rob_index;
        logic [FU_W-1:0]   fu;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-requester pick: grants the requester that is older than every other requester.
module rs_age_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]            req,
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
    output logic [DEPTH-1:0]            grant,
    output logic                        found
);

    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = req[i];
            for (int j = 0; j < DEPTH; j++) begin
                grant[i] = grant[i] & ((i == j) | ~req[j] | older[i][j]);
            end
        end
    end

    assign found = |grant;

endmodule

// File: rtl/rs_issue_queue.sv
// Age-ordered reservation station: dual dispatch, tag wakeup with insert bypass,
// oldest-ready issue per functional-unit port, flush.
module rs_issue_queue
    import rs_issue_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ISSUE_W = 2,
    parameter int WAKE_W  = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             valid_in_1,
    input  logic                             valid_in_2,
    input  dispatch_pipeline_data            instr1,
    input  dispatch_pipeline_data            instr2,
    output logic                             ready_in,
    output logic                             ready_in2,
    input  logic [1:0]                       pr1_rdy_in,
    input  logic [1:0]                       pr2_rdy_in,
    input  logic [WAKE_W-1:0]                wake_valid,
    input  logic [WAKE_W-1:0][PREG_W-1:0]    wake_tag,
    input  logic [ISSUE_W-1:0]               fu_rdy,
    output logic [ISSUE_W-1:0]               valid_issue,
    output rs_entry_t [ISSUE_W-1:0]          data_out,
    input  logic                             flush,
    output logic [$clog2(DEPTH):0]           occupancy
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    rs_entry_t                     entries   [DEPTH];
    rs_entry_t                     entries_n [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0]   older, older_n;
    logic [FU_W-1:0]               rr, rr_n;
    logic [OCC_W-1:0]              occ_n;
    logic                          acc1, acc2;
    logic [DEPTH-1:0]              ins1_oh, ins2_oh;
    rs_entry_t                     new1, new2;
    logic [ISSUE_W-1:0][DEPTH-1:0] req, grant;
    logic [ISSUE_W-1:0]            found, fire;
    rs_entry_t [ISSUE_W-1:0]       data_n;

    function automatic logic [FU_W-1:0] rr_add(input logic [FU_W-1:0] base, input int inc);
        return FU_W'((int'(base) + inc) % ISSUE_W);
    endfunction

    // x0 is hardwired ready; a same-cycle broadcast bypasses the busy table.
    function automatic logic src_rdy(input logic [PREG_W-1:0] tag, input logic busy_rdy,
                                     input logic [WAKE_W-1:0] wv,
                                     input logic [WAKE_W-1:0][PREG_W-1:0] wt);
        logic r;
        r = busy_rdy | (tag == {PREG_W{1'b0}});
        for (int w = 0; w < WAKE_W; w++) begin
            r = r | (wv[w] & (wt[w] == tag));
        end
        return r;
    endfunction

    function automatic rs_entry_t make_entry(input dispatch_pipeline_data d, input logic r1,
                                             input logic r2, input logic [FU_W-1:0] fu);
        rs_entry_t e;
        e.valid     = 1'b1;
        e.opcode    = d.opcode;
        e.prd       = d.prd;
        e.pr1       = d.pr1;
        e.pr1_ready = r1;
        e.pr2       = d.pr2;
        e.pr2_ready = r2;
        e.imm       = d.imm;
        e.rob_index = d.rob_index;
        e.fu        = fu;
        return e;
    endfunction

    assign ready_in  = ~reset & (occupancy < OCC_W'(DEPTH));
    assign ready_in2 = ~reset & (occupancy <= OCC_W'(DEPTH - 2));

    assign new1 = make_entry(instr1,
                             src_rdy(instr1.pr1, pr1_rdy_in[0], wake_valid, wake_tag),
                             src_rdy(instr1.pr2, pr2_rdy_in[0], wake_valid, wake_tag), rr);
    assign new2 = make_entry(instr2,
                             src_rdy(instr2.pr1, pr1_rdy_in[1], wake_valid, wake_tag),
                             src_rdy(instr2.pr2, pr2_rdy_in[1], wake_valid, wake_tag),
                             rr_add(rr, 1));

    // Two lowest free indices; slot 2 only ever rides along with slot 1.
    always_comb begin
        logic seen1, seen2;
        acc1    = valid_in_1 & ready_in;
        acc2    = acc1 & valid_in_2 & ready_in2;
        ins1_oh = '0;
        ins2_oh = '0;
        seen1   = 1'b0;
        seen2   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ins1_oh[i] = acc1 & ~entries[i].valid & ~seen1;
            ins2_oh[i] = acc2 & ~entries[i].valid & seen1 & ~seen2;
            seen2      = seen2 | (~entries[i].valid & seen1);
            seen1      = seen1 | ~entries[i].valid;
        end
    end

    always_comb begin
        req = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                req[p][i] = entries[i].valid & entries[i].pr1_ready & entries[i].pr2_ready
                          & (entries[i].fu == FU_W'(p));
            end
        end
    end

    for (genvar p = 0; p < ISSUE_W; p++) begin : g_sel
        rs_age_select #(.DEPTH(DEPTH)) u_sel (
            .req   (req[p]),
            .older (older),
            .grant (grant[p]),
            .found (found[p])
        );
    end

    always_comb begin
        rs_entry_t e;
        int        issued;
        fire    = found & fu_rdy;
        data_n  = data_out;
        issued  = 0;
        older_n = older;
        for (int p = 0; p < ISSUE_W; p++) begin
            if (fire[p]) begin
                issued = issued + 1;
                for (int i = 0; i < DEPTH; i++) begin
                    data_n[p] = grant[p][i] ? entries[i] : data_n[p];
                end
            end else begin
                data_n[p] = data_out[p];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            e = entries[i];
            for (int w = 0; w < WAKE_W; w++) begin
                e.pr1_ready = e.pr1_ready | (wake_valid[w] & (wake_tag[w] == e.pr1));
                e.pr2_ready = e.pr2_ready | (wake_valid[w] & (wake_tag[w] == e.pr2));
            end
            for (int p = 0; p < ISSUE_W; p++) begin
                e.valid = e.valid & ~(fire[p] & grant[p][i]);
            end
            entries_n[i] = ins1_oh[i] ? new1 : (ins2_oh[i] ? new2 : e);
        end
        // New rows are younger than everything; slot 1 is older than slot 2.
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (ins1_oh[i]) begin
                    older_n[i][j] = ins2_oh[j];
                end else if (ins2_oh[i]) begin
                    older_n[i][j] = 1'b0;
                end else if (ins1_oh[j] | ins2_oh[j]) begin
                    older_n[i][j] = 1'b1;
                end else begin
                    older_n[i][j] = older[i][j];
                end
            end
        end
        rr_n  = rr_add(rr, int'(acc1) + int'(acc2));
        occ_n = OCC_W'(int'(occupancy) + int'(acc1) + int'(acc2) - issued);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            older       <= '0;
            rr          <= '0;
            occupancy   <= '0;
            valid_issue <= '0;
            data_out    <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
            rr          <= '0;
            occupancy   <= '0;
            valid_issue <= '0;
        end else begin
            entries     <= entries_n;
            older       <= older_n;
            rr          <= rr_n;
            occupancy   <= occ_n;
            valid_issue <= fire;
            data_out    <= data_n;
        end
    end

endmodule
